// File: rtl/control_pkg.sv
// Shared opcode/state encodings and datapath select constants for control_unit.
package control_pkg;

  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_BGT  = 5'b01010,
    OP_BGE  = 5'b01011,
    OP_BLT  = 5'b01100,
    OP_BLE  = 5'b01101,
    OP_JMP  = 5'b01110
  } opcode_t;

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_MEM_WAIT,
    S_EXECUTE,
    S_HALT
  } state_t;

  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_EXT = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Opcodes whose operand addresses data memory need an extra read-latency cycle.
  function automatic logic needs_mem(input logic [4:0] op);
    return (op == OP_STO) || (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/control_unit_program_counter.sv
// Program counter register: load has priority over increment; wraps at 2^WIDTH.
module program_counter #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic             inc_en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load_en) begin
      pc <= load_value;
    end else if (inc_en) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle fetch/decode/execute sequencer for the 16-bit accumulator datapath.
// Define CONTROL_BRANCH_EN to enable flag-conditional branches (opcodes 01000-01101).
module control_unit
  import control_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH = 11,
  parameter int unsigned DATA_WIDTH    = 16
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic [DATA_WIDTH-1:0]    instruction_in,
  input  logic                     flag_Z_in,
  input  logic                     flag_N_in,
  output logic [OPERAND_WIDTH-1:0] pc_out,
  output logic [OPERAND_WIDTH-1:0] operand_out,
  output logic                     alu_op_out,
  output logic [1:0]               sel_A_out,
  output logic                     sel_B_out,
  output logic                     acc_wr_out,
  output logic                     acc_reset_out,
  output logic                     status_wr_out,
  output logic                     status_reset_out,
  output logic                     data_memory_wr_out,
  output logic                     halted_out
);

  localparam int unsigned OPCODE_WIDTH = DATA_WIDTH - OPERAND_WIDTH;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   ir;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    pc_load;
  logic                    pc_inc;

  assign opcode      = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign operand_out = ir[OPERAND_WIDTH-1:0];

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= S_INIT;
      ir    <= '0;
    end else begin
      case (state)
        S_INIT:     state <= S_FETCH;
        S_FETCH:    state <= S_DECODE;
        S_DECODE: begin
          ir    <= instruction_in;
          state <= needs_mem(instruction_in[DATA_WIDTH-1 -: OPCODE_WIDTH]) ? S_MEM_WAIT : S_EXECUTE;
        end
        S_MEM_WAIT: state <= S_EXECUTE;
        S_EXECUTE:  state <= (opcode == OP_HLT) ? S_HALT : S_FETCH;
        S_HALT:     state <= S_HALT;
        default:    state <= S_INIT;
      endcase
    end
  end

`ifdef CONTROL_BRANCH_EN
  logic branch_taken;

  always_comb begin
    branch_taken = 1'b0;
    case (opcode)
      OP_BEQ:  branch_taken = flag_Z_in;
      OP_BNE:  branch_taken = !flag_Z_in;
      OP_BGT:  branch_taken = !flag_Z_in && !flag_N_in;
      OP_BGE:  branch_taken = !flag_N_in;
      OP_BLT:  branch_taken = flag_N_in;
      OP_BLE:  branch_taken = flag_Z_in || flag_N_in;
      default: branch_taken = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags = flag_Z_in | flag_N_in;
`endif

  // Controls decode from state+IR so an async reset drops them in the same cycle.
  always_comb begin
    alu_op_out         = ALU_ADD;
    sel_A_out          = SEL_A_MEM;
    sel_B_out          = 1'b0;
    acc_wr_out         = 1'b0;
    status_wr_out      = 1'b0;
    data_memory_wr_out = 1'b0;
    pc_load            = 1'b0;
    pc_inc             = 1'b0;
    if (state == S_EXECUTE) begin
      case (opcode)
        OP_HLT: ;
        OP_STO: begin
          data_memory_wr_out = 1'b1;
          pc_inc             = 1'b1;
        end
        OP_LD, OP_LDI: begin
          sel_A_out     = (opcode == OP_LDI) ? SEL_A_EXT : SEL_A_MEM;
          acc_wr_out    = 1'b1;
          status_wr_out = 1'b1;
          pc_inc        = 1'b1;
        end
        OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
          sel_A_out     = SEL_A_ALU;
          sel_B_out     = (opcode == OP_ADDI) || (opcode == OP_SUBI);
          alu_op_out    = ((opcode == OP_SUB) || (opcode == OP_SUBI)) ? ALU_SUB : ALU_ADD;
          acc_wr_out    = 1'b1;
          status_wr_out = 1'b1;
          pc_inc        = 1'b1;
        end
        OP_JMP: pc_load = 1'b1;
`ifdef CONTROL_BRANCH_EN
        OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE: begin
          pc_load = branch_taken;
          pc_inc  = !branch_taken;
        end
`endif
        default: pc_inc = 1'b1;
      endcase
    end
  end

  assign acc_reset_out    = (state == S_INIT);
  assign status_reset_out = (state == S_INIT);
  assign halted_out       = (state == S_HALT);

  program_counter #(
    .WIDTH(OPERAND_WIDTH)
  ) u_program_counter (
    .clk        (clock_in),
    .rst_n      (reset_n_in),
    .load_en    (pc_load),
    .inc_en     (pc_inc),
    .load_value (ir[OPERAND_WIDTH-1:0]),
    .pc         (pc_out)
  );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction table, reset corner cases, random stream vs model.
`timescale 1ns/1ps
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        flag_z, flag_n;
  logic [10:0] pc_out, operand_out;
  logic        alu_op, sel_b, acc_wr, acc_reset, status_wr, status_reset, dm_wr, halted;
  logic [1:0]  sel_a;

  control_unit #(
    .OPERAND_WIDTH(11),
    .DATA_WIDTH   (16)
  ) dut (
    .clock_in          (clk),
    .reset_n_in        (rst_n),
    .instruction_in    (instr),
    .flag_Z_in         (flag_z),
    .flag_N_in         (flag_n),
    .pc_out            (pc_out),
    .operand_out       (operand_out),
    .alu_op_out        (alu_op),
    .sel_A_out         (sel_a),
    .sel_B_out         (sel_b),
    .acc_wr_out        (acc_wr),
    .acc_reset_out     (acc_reset),
    .status_wr_out     (status_wr),
    .status_reset_out  (status_reset),
    .data_memory_wr_out(dm_wr),
    .halted_out        (halted)
  );

  always #5 clk = ~clk;

  // Program memory with registered read.
  logic [15:0] pmem [2048];
  always @(posedge clk) instr <= pmem[pc_out];

  typedef struct {
    int unsigned cyc;
    logic [9:0]  ctrl;
    logic [10:0] npc;
    bit          halt;
  } exp_t;

  typedef struct {
    logic [15:0] ins;
    bit          z;
    bit          n;
    exp_t        e;
  } vec_t;

  localparam int NV = 14;
`ifdef CONTROL_BRANCH_EN
  localparam logic [10:0] BEQ_T = 11'h020;
`else
  localparam logic [10:0] BEQ_T = 11'h006;
`endif

  vec_t        vecs [NV];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [10:0] pc_model = '0;

  // {alu_op, sel_A[1:0], sel_B, acc_wr, status_wr, dm_wr, acc_reset, status_reset, halted}
  function automatic logic [9:0] ctrl_now();
    return {alu_op, sel_a, sel_b, acc_wr, status_wr, dm_wr, acc_reset, status_reset, halted};
  endfunction

  function automatic vec_t mkv(input logic [15:0] ins, input bit z, input int unsigned cyc,
                               input logic [9:0] ctrl, input logic [10:0] npc, input bit halt);
    vec_t v;
    v.ins = ins; v.z = z; v.n = 1'b0;
    v.e.cyc = cyc; v.e.ctrl = ctrl; v.e.npc = npc; v.e.halt = halt;
    return v;
  endfunction

  // Instruction-level reference: cycle count, EXECUTE controls and next PC from the ISA rules.
  function automatic exp_t model(input logic [15:0] ins, input logic [10:0] pc, input bit z, input bit n);
    exp_t        e;
    int unsigned op = 32'(ins[15:11]);
    logic [10:0] target = ins[10:0];
    bit          alu = 1'b0, selb = 1'b0, accw = 1'b0, stw = 1'b0, dm = 1'b0, take = 1'b0;
    logic [1:0]  sela = 2'd0;
    e.halt = 1'b0;
    e.npc  = pc + 11'd1;
    e.cyc  = (op inside {1, 2, 4, 6}) ? 4 : 3;
    if (op == 0) begin
      e.halt = 1'b1;
      e.npc  = pc;
    end else if (op == 1) begin
      dm = 1'b1;
    end else if (op == 2 || op == 3) begin
      sela = (op == 3) ? 2'd1 : 2'd0;
      accw = 1'b1; stw = 1'b1;
    end else if (op >= 4 && op <= 7) begin
      sela = 2'd2;
      selb = (op == 5 || op == 7);
      alu  = (op >= 6);
      accw = 1'b1; stw = 1'b1;
    end else if (op == 14) begin
      e.npc = target;
    end
`ifdef CONTROL_BRANCH_EN
    else if (op >= 8 && op <= 13) begin
      case (op)
        8:       take = z;
        9:       take = !z;
        10:      take = !z && !n;
        11:      take = !n;
        12:      take = n;
        default: take = z || n;
      endcase
      if (take) e.npc = target;
    end
`endif
    e.ctrl = {alu, sela, selb, accw, stw, dm, 1'b0, 1'b0, 1'b0};
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Holds reset 3 cycles, releases just after a rising edge; leaves the bench at the FETCH sample.
  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ctrl", 32'(ctrl_now()), 32'h006);
    check("reset pc", 32'(pc_out), 32'd0);
    check("reset operand", 32'(operand_out), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("init ctrl", 32'(ctrl_now()), 32'h006);
    @(negedge clk);
    check("fetch ctrl after init", 32'(ctrl_now()), 32'h000);
    pc_model = '0;
  endtask

  // Called at the FETCH sample point; returns at the next FETCH sample (or after HALT checks).
  task automatic exec_one(input string tag, input logic [15:0] ins, input bit z, input bit n,
                          input exp_t e);
    bit idle_ok = 1'b1;
    pmem[pc_model] = ins;
    flag_z = z;
    flag_n = n;
    check({tag, " fetch pc"}, 32'(pc_out), 32'(pc_model));
    for (int unsigned c = 1; c < e.cyc; c++) begin
      if (ctrl_now() != 10'h000) idle_ok = 1'b0;
      if (c == 3 && operand_out != ins[10:0]) idle_ok = 1'b0;
      @(negedge clk);
    end
    check({tag, " pre-exec quiet"}, 32'(idle_ok), 32'd1);
    check({tag, " exec ctrl"}, 32'(ctrl_now()), 32'(e.ctrl));
    check({tag, " exec operand"}, 32'(operand_out), 32'(ins[10:0]));
    @(negedge clk);
    if (e.halt) begin
      check({tag, " halt ctrl"}, 32'(ctrl_now()), 32'h001);
      check({tag, " halt pc"}, 32'(pc_out), 32'(pc_model));
      repeat (3) @(negedge clk);
      check({tag, " halt sticky"}, 32'({ctrl_now(), pc_out}), 32'({10'h001, pc_model}));
    end else begin
      check({tag, " next pc"}, 32'(pc_out), 32'(e.npc));
      pc_model = e.npc;
    end
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 2048; i++) pmem[i] = 16'h0000;
    flag_z = 1'b0;
    flag_n = 1'b0;

    vecs[0]  = mkv(16'h1004, 1'b0, 4, 10'h030, 11'h001, 1'b0); // LD 4
    vecs[1]  = mkv(16'h3009, 1'b0, 4, 10'h330, 11'h002, 1'b0); // SUB 9
    vecs[2]  = mkv(16'h3801, 1'b0, 3, 10'h370, 11'h003, 1'b0); // SUBI 1
    vecs[3]  = mkv(16'h2002, 1'b0, 4, 10'h130, 11'h004, 1'b0); // ADD 2
    vecs[4]  = mkv(16'h7800, 1'b0, 3, 10'h000, 11'h005, 1'b0); // NOP
    vecs[5]  = mkv(16'h4020, 1'b1, 3, 10'h000, BEQ_T,   1'b0); // BEQ 0x20, Z=1
    vecs[6]  = mkv(16'h7100, 1'b0, 3, 10'h000, 11'h100, 1'b0); // JMP 0x100
    vecs[7]  = mkv(16'h4020, 1'b0, 3, 10'h000, 11'h101, 1'b0); // BEQ 0x20, Z=0
    vecs[8]  = mkv(16'h77FF, 1'b0, 3, 10'h000, 11'h7FF, 1'b0); // JMP 0x7FF
    vecs[9]  = mkv(16'h7800, 1'b0, 3, 10'h000, 11'h000, 1'b0); // NOP at 2047 wraps
    vecs[10] = mkv(16'h1805, 1'b0, 3, 10'h0B0, 11'h001, 1'b0); // LDI 5
    vecs[11] = mkv(16'h2803, 1'b0, 3, 10'h170, 11'h002, 1'b0); // ADDI 3
    vecs[12] = mkv(16'h0807, 1'b0, 4, 10'h008, 11'h003, 1'b0); // STO 7
    vecs[13] = mkv(16'h0000, 1'b0, 3, 10'h000, 11'h003, 1'b1); // HLT at 3

    reset_dut();
    for (int i = 0; i < NV; i++)
      exec_one($sformatf("vec%0d", i), vecs[i].ins, vecs[i].z, vecs[i].n, vecs[i].e);

    // Reset asserted in the EXECUTE cycle of an ADD.
    reset_dut();
    exec_one("rst jmp", 16'h7055, 1'b0, 1'b0, model(16'h7055, pc_model, 1'b0, 1'b0));
    pmem[pc_model] = 16'h2002;
    repeat (3) @(negedge clk);
    check("rst acc_wr before", 32'(acc_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst acc_wr dropped", 32'(acc_wr), 32'd0);
    check("rst pc cleared", 32'(pc_out), 32'd0);
    check("rst ctrl", 32'(ctrl_now()), 32'h006);
    reset_dut();

    for (int i = 0; i < 200; i++) begin
      logic [4:0]  op;
      logic [15:0] ins;
      bit          z, n;
      op = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 24) == 0) op = 5'd0;
      ins = {op, 11'($urandom)};
      z = 1'($urandom);
      n = 1'($urandom);
      e = model(ins, pc_model, z, n);
      exec_one("rand", ins, z, n, e);
      if (e.halt) reset_dut();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
